// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel DMA copy engine.
package dma_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_RUN,
        DMA_DONE
    } dma_state_t;

    localparam int unsigned DMA_DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned WORD_BYTES             = DMA_DEFAULT_DATA_WIDTH / 8;
    localparam int unsigned DMA_CNT_W              = 16;
    localparam int unsigned DMA_MAX_WORDS          = 16383;

    function automatic int unsigned byte_shift(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/dma_fifo.sv
// Synchronous word FIFO buffering read data between the read and write sides.
// Push while full is only honoured when a pop happens in the same cycle.
module dma_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, the slot written is the one being popped this cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dma_engine.sv
// Single-channel word copy engine: credit-limited read issuer feeding a FIFO drained by a writer.
// Optional busy-cycle counter port dma_cycles is built when DMA_PERF_CNT_EN is defined.
module dma_engine
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = DMA_DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [15:0]           length,
    output logic                  dma_done,
    output logic                  dma_busy,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic [DATA_WIDTH-1:0] wr_req_data
`ifdef DMA_PERF_CNT_EN
    ,
    output logic [31:0]           dma_cycles
`endif
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int unsigned SHIFT          = byte_shift(DATA_WIDTH);
    localparam int unsigned CNT_W          = DMA_CNT_W;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES_PER_WORD - 1));
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES_PER_WORD);

    dma_state_t state;
    dma_state_t state_nxt;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CNT_W-1:0]      words_total;
    logic [CNT_W-1:0]      words_req;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      outstanding;
    logic                  start_ok;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign words_req   = length >> SHIFT;
    assign start_ok    = (state == DMA_IDLE) && dma_start;
    // Reads issued but not yet written cover both in-flight and buffered words.
    assign outstanding = rd_cnt - wr_cnt;
    assign rd_fire     = rd_req_valid && rd_req_ready;
    assign wr_fire     = wr_req_valid && wr_req_ready;
    assign fifo_push   = rd_rsp_valid && (state == DMA_RUN);

    assign rd_req_addr  = rd_addr;
    assign wr_req_addr  = wr_addr;
    assign wr_req_valid = !fifo_empty;
    assign wr_req_data  = fifo_empty ? '0 : fifo_head;

    dma_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rd_rsp_data),
        .pop       (wr_fire),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= DMA_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        dma_done     = 1'b0;
        dma_busy     = 1'b0;
        rd_req_valid = 1'b0;
        case (state)
            DMA_IDLE: begin
                if (dma_start) state_nxt = (words_req == '0) ? DMA_DONE : DMA_RUN;
            end
            DMA_RUN: begin
                dma_busy     = 1'b1;
                rd_req_valid = (rd_cnt < words_total) && (outstanding < CNT_W'(FIFO_DEPTH));
                if (wr_fire && ((wr_cnt + CNT_W'(1)) == words_total)) state_nxt = DMA_DONE;
            end
            DMA_DONE: begin
                dma_busy  = 1'b1;
                dma_done  = 1'b1;
                state_nxt = DMA_IDLE;
            end
            default: state_nxt = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr     <= '0;
            wr_addr     <= '0;
            words_total <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else if (start_ok) begin
            rd_addr     <= src_addr & ALIGN_MASK;
            wr_addr     <= dst_addr & ALIGN_MASK;
            words_total <= words_req;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else begin
            if (rd_fire) begin
                rd_addr <= rd_addr + ADDR_STEP;
                rd_cnt  <= rd_cnt + CNT_W'(1);
            end
            if (wr_fire) begin
                wr_addr <= wr_addr + ADDR_STEP;
                wr_cnt  <= wr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DMA_PERF_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         cycle_cnt <= '0;
        else if (start_ok)                               cycle_cnt <= '0;
        else if ((state == DMA_RUN) && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign dma_cycles = cycle_cnt;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) fifo_push |-> !fifo_full);
    a_buffer_le_credit: assert property (@(posedge clk) disable iff (rst)
        32'(fifo_count) <= 32'(outstanding));

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: memory/responder model, randomized handshakes, directed corner cases.
module tb_dma_engine;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [15:0]   length;
    logic          dma_done;
    logic          dma_busy;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
`ifdef DMA_PERF_CNT_EN
    logic [31:0]   dma_cycles;
`endif

    always #5 clk = ~clk;

    dma_engine #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_start    (dma_start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .dma_done     (dma_done),
        .dma_busy     (dma_busy),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data)
`ifdef DMA_PERF_CNT_EN
        ,
        .dma_cycles   (dma_cycles)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        finished = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Transfer model: expected word n lives at base + 4n, data is a pure function of source address.
    logic [31:0] cur_src, cur_dst, data_seed;
    int unsigned cur_words, n_rd, n_wr, done_cnt, busy_cycles, valid_seen;
    int unsigned cyc = 0;
    int unsigned rmode = 0, wmode = 0, rsp_delay = 1, wr_block_until = 0;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } rsp_t;
    rsp_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ data_seed;
    endfunction

    // Memory responder and output monitor, acting on the falling edge.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        prev_stall   = 1'b0;
        prev_addr    = '0;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend.delete();
                rd_rsp_valid = 1'b0;
                rd_rsp_data  = '0;
                prev_stall   = 1'b0;
                continue;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                rd_rsp_valid = 1'b0;
                rd_rsp_data  = '0;
            end
            rd_req_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check_eq("rd_hold_valid", 64'(rd_req_valid), 64'(1'b1));
                check_eq("rd_hold_addr", 64'(rd_req_addr), 64'(prev_addr));
            end
            if (rd_req_valid || wr_req_valid) valid_seen++;
            if (dma_busy) busy_cycles++;
            if (dma_done) done_cnt++;
            if (rd_req_valid && rd_req_ready) begin
                check_eq("rd_addr", 64'(rd_req_addr), 64'(cur_src + 32'(n_rd * 4)));
                n_rd++;
                check_eq("rd_credit", 64'((n_rd - n_wr) <= DEPTH), 64'(1'b1));
                check_eq("rd_count", 64'(n_rd <= cur_words), 64'(1'b1));
                pend.push_back('{data: mem_word(rd_req_addr), due: cyc + rsp_delay});
            end
            prev_stall = rd_req_valid && !rd_req_ready;
            prev_addr  = rd_req_addr;
            case (wmode)
                0:       wr_req_ready = 1'b1;
                1:       wr_req_ready = 1'($urandom_range(0, 1));
                default: wr_req_ready = (cyc >= wr_block_until);
            endcase
            if (wr_req_valid && wr_req_ready) begin
                check_eq("wr_addr", 64'(wr_req_addr), 64'(cur_dst + 32'(n_wr * 4)));
                check_eq("wr_data", 64'(wr_req_data), 64'(mem_word(cur_src + 32'(n_wr * 4))));
                n_wr++;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
        @(negedge clk);
        cur_src     = s & ~32'h3;
        cur_dst     = d & ~32'h3;
        cur_words   = 32'(len >> 2);
        n_rd        = 0;
        n_wr        = 0;
        done_cnt    = 0;
        busy_cycles = 0;
        valid_seen  = 0;
        src_addr    = s;
        dst_addr    = d;
        length      = len;
        dma_start   = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        check_eq("start_busy", 64'(dma_busy), 64'(1'b1));
        check_eq("start_rd_valid", 64'(rd_req_valid), 64'(cur_words != 0));
    endtask

    task automatic finish_xfer(input string tag);
        @(negedge clk);
        @(negedge clk);
        check_eq({tag, "_done_once"}, 64'(done_cnt), 64'(1));
        check_eq({tag, "_reads"}, 64'(n_rd), 64'(cur_words));
        check_eq({tag, "_writes"}, 64'(n_wr), 64'(cur_words));
        check_eq({tag, "_idle"}, 64'(dma_busy), 64'(1'b0));
`ifdef DMA_PERF_CNT_EN
        check_eq({tag, "_cycles"}, 64'(dma_cycles), 64'(busy_cycles - 1));
`endif
    endtask

    task automatic wait_done(input string tag);
        int unsigned k = 0;
        while (!dma_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_no_timeout"}, 64'(k < 3000), 64'(1'b1));
        finish_xfer(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rdv"}, 64'(rd_req_valid), 64'(0));
        check_eq({tag, "_rda"}, 64'(rd_req_addr), 64'(0));
        check_eq({tag, "_wrv"}, 64'(wr_req_valid), 64'(0));
        check_eq({tag, "_wra"}, 64'(wr_req_addr), 64'(0));
        check_eq({tag, "_wrd"}, 64'(wr_req_data), 64'(0));
        check_eq({tag, "_done"}, 64'(dma_done), 64'(0));
        check_eq({tag, "_busy"}, 64'(dma_busy), 64'(0));
    endtask

    initial begin
        int unsigned k;
        data_seed = $urandom;
        rst       = 1'b1;
        dma_start = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic 4-word copy with immediate ready and one-cycle response.
        rmode = 0; wmode = 0; rsp_delay = 1;
        start_xfer(32'h100, 32'h800, 16'd16);
        check_eq("basic_first_addr", 64'(rd_req_addr), 64'(32'h100));
        wait_done("basic");

        // Zero-word requests complete without any port traffic.
        for (int i = 0; i < 2; i++) begin
            start_xfer(32'h200, 32'h300, (i == 0) ? 16'd0 : 16'd3);
            check_eq("zero_done", 64'(dma_done), 64'(1'b1));
            @(negedge clk);
            check_eq("zero_done_low", 64'(dma_done), 64'(1'b0));
            check_eq("zero_busy_low", 64'(dma_busy), 64'(1'b0));
            check_eq("zero_no_valid", 64'(valid_seen), 64'(0));
            check_eq("zero_busy_len", 64'(busy_cycles), 64'(1));
        end

        // Writer blocked: reads must stop at the buffer depth.
        wmode = 2; wr_block_until = cyc + 40;
        start_xfer(32'h1000, 32'h2000, 16'd64);
        repeat (30) @(negedge clk);
        check_eq("stall_reads", 64'(n_rd), 64'(DEPTH));
        check_eq("stall_writes", 64'(n_wr), 64'(0));
        wait_done("stall");

        // Randomized handshakes, slower responses, random alignment and wrapping addresses.
        rmode = 1; wmode = 1; rsp_delay = 3;
        for (int i = 0; i < 8; i++) begin
            start_xfer((i == 0) ? 32'hFFFF_FFF6 : $urandom, $urandom,
                       (i == 1) ? 16'd4 : 16'($urandom_range(0, 80)));
            wait_done("rand");
        end

        // Start pulses during RUN and in the DONE cycle are ignored.
        rmode = 0; wmode = 1; rsp_delay = 1;
        start_xfer(32'h4000, 32'h5000, 16'd40);
        repeat (3) @(negedge clk);
        src_addr = 32'h9000; length = 16'd8; dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        check_eq("run_start_busy", 64'(dma_busy), 64'(1'b1));
        k = 0;
        while (!dma_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_start_no_timeout", 64'(k < 3000), 64'(1'b1));
        src_addr = 32'hA000; length = 16'd16; dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        check_eq("done_start_ignored", 64'(dma_busy), 64'(1'b0));
        check_eq("done_start_no_rd", 64'(rd_req_valid), 64'(1'b0));
        finish_xfer("restart");
        start_xfer(32'hA000, 32'hB000, 16'd16);
        wait_done("fresh");

        // Reset in the middle of an 8-word transfer.
        rmode = 0; wmode = 0; rsp_delay = 1;
        start_xfer(32'h6000, 32'h7000, 16'd32);
        k = 0;
        while (n_wr < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("rst_reach_word3", 64'(k < 200), 64'(1'b1));
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_no_done", 64'(done_cnt), 64'(0));
        start_xfer(32'h6100, 32'h7100, 16'd32);
        wait_done("after_rst");

        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        check_eq("watchdog", 64'(finished), 64'(1'b1));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
